// File: rtl/iter_divider.sv
// Sequential 16-by-8 unsigned restoring divider, one quotient bit per clock, Load/Done handshake.
// Optional macro ITER_DIVIDER_DIVZERO_TRAP_EN: divide-by-zero short-circuits to DONE with DivZero set.
module iter_divider (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Load,
    input  logic [15:0] Dividend,
    input  logic [7:0]  Divisor,
    output logic [15:0] Quotient,
    output logic [7:0]  Remainder,
    output logic        Done,
    output logic        Busy,
    output logic        DivZero
);

    localparam int unsigned DW = 16;
    localparam int unsigned VW = 8;
    localparam int unsigned RW = VW + 1;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   q, q_nxt;
    logic [VW-1:0]   d, d_nxt;
    logic [RW-1:0]   r, r_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [DW-1:0]   quotient_nxt;
    logic [VW-1:0]   remainder_nxt;
    logic            done_nxt;
    logic            busy_nxt;

    // One restoring step: shift the next dividend bit into the partial remainder and try D.
    logic [RW-1:0]   trial;
    logic            fits;
    logic [RW-1:0]   diff;

    assign trial = {r[VW-1:0], q[DW-1]};
    assign fits  = (trial >= {1'b0, d});
    assign diff  = trial - {1'b0, d};

`ifdef ITER_DIVIDER_DIVZERO_TRAP_EN
    logic divzero_q, divzero_nxt;
    assign DivZero = divzero_q;
`else
    assign DivZero = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        q_nxt         = q;
        d_nxt         = d;
        r_nxt         = r;
        cnt_nxt       = cnt;
        quotient_nxt  = Quotient;
        remainder_nxt = Remainder;
        done_nxt      = 1'b0;
`ifdef ITER_DIVIDER_DIVZERO_TRAP_EN
        divzero_nxt   = divzero_q;
`endif

        case (state)
            IDLE: begin
                if (Load) begin
`ifdef ITER_DIVIDER_DIVZERO_TRAP_EN
                    if (Divisor == '0) begin
                        quotient_nxt  = '1;
                        remainder_nxt = Dividend[VW-1:0];
                        done_nxt      = 1'b1;
                        divzero_nxt   = 1'b1;
                        state_nxt     = DONE;
                    end else
`endif
                    begin
                        q_nxt     = Dividend;
                        d_nxt     = Divisor;
                        r_nxt     = '0;
                        cnt_nxt   = '0;
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                r_nxt   = fits ? diff : trial;
                q_nxt   = {q[DW-2:0], fits};
                cnt_nxt = cnt + CW'(1);
                if (cnt == LAST_STEP) begin
                    quotient_nxt  = {q[DW-2:0], fits};
                    remainder_nxt = fits ? diff[VW-1:0] : trial[VW-1:0];
                    done_nxt      = 1'b1;
`ifdef ITER_DIVIDER_DIVZERO_TRAP_EN
                    divzero_nxt   = 1'b0;
`endif
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            q         <= '0;
            d         <= '0;
            r         <= '0;
            cnt       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            Done      <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            q         <= q_nxt;
            d         <= d_nxt;
            r         <= r_nxt;
            cnt       <= cnt_nxt;
            Quotient  <= quotient_nxt;
            Remainder <= remainder_nxt;
            Done      <= done_nxt;
            Busy      <= busy_nxt;
        end
    end

`ifdef ITER_DIVIDER_DIVZERO_TRAP_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            divzero_q <= 1'b0;
        end else begin
            divzero_q <= divzero_nxt;
        end
    end
`endif

endmodule

// File: doc/iter_divider.md
# iter_divider

Sequential 16-bit by 8-bit unsigned restoring divider, the inverse of the ALU's iterative multiplier. It produces one quotient bit per clock and uses the same Load/Done handshake as the multiplier. It is intended as the next ALU opcode extension: the ALU presents operands and pulses Load, then captures Quotient/Remainder on Done.

## Interface
Parameters:
- none. Widths are fixed at 16-bit dividend and 8-bit divisor.

Ports:
- Clk  input  1  clock; all state changes on posedge
- Rst  input  1  one clock; reset is synchronous and active-high
- Load  input  1  start request; sampled only in IDLE
- Dividend  input  16  unsigned dividend; captured when Load is accepted
- Divisor  input  8  unsigned divisor; captured when Load is accepted
- Quotient  output  16  registered quotient; held until the next Done
- Remainder  output  8  registered remainder; held until the next Done
- Done  output  1  one-cycle pulse; results are valid in that cycle and stay valid after it
- Busy  output  1  high while not in IDLE
- DivZero  output  1  divide-by-zero flag; updated with Done

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE.
- Reset values: Quotient=0, Remainder=0, Done=0, Busy=0, DivZero=0. The iteration counter and working registers are also cleared.
- IDLE, Load=1:
  - Capture the dividend into shift register Q and the divisor into D.
  - Clear the 9-bit partial remainder R and the counter.
  - Go to CALC.
- IDLE, Load=0: stay in IDLE.
- CALC performs one step per cycle:
  - T = {R[7:0], Q[15]}.
  - If T >= {1'b0, D}: R <= T - D and shift 1 into Q.
  - Otherwise: R <= T and shift 0 into Q.
  - The counter increments each step.
- After the 16th step: Quotient <= Q (post-shift), Remainder <= R[7:0], Done <= 1, DivZero <= 0, go to DONE.
- DONE: Done <= 0, go to IDLE.
- Load is ignored in CALC and DONE. It is not queued.
- Operand inputs may change freely after Load is accepted.
- Arithmetic:
  - Unsigned only.
  - Comparison and subtraction are 9 bits wide, so R never overflows.
  - For Divisor != 0: Dividend = Quotient*Divisor + Remainder, with Remainder < Divisor.
- Divisor = 0 without the trap: every step subtracts 0, giving Quotient=16'hFFFF and Remainder=Dividend[7:0].

## Timing
- Load is accepted at edge E0.
- CALC steps occur at edges E1 through E16.
- Done, Quotient, Remainder and DivZero are registered at E16 and visible during cycle E16–E17.
- The state returns to IDLE at E17. The earliest next Load acceptance is E18.
- Latency is 16 cycles from acceptance to Done. Throughput is one divide per 18 cycles.
- Busy is high from E0+ through the Done cycle and low after E17.
- Rst has priority over everything. Asserted mid-CALC, it aborts the operation: no Done is produced and all outputs return to their reset values at that edge.
- Load and Rst asserted on the same edge: Rst wins and Load is dropped.
- Load held high continuously starts a new divide each time the block passes through IDLE.

## Configuration
- Macro: ITER_DIVIDER_DIVZERO_TRAP_EN.
- Defined:
  - Load accepted with Divisor=0 skips CALC and goes straight to DONE.
  - Quotient=16'hFFFF, Remainder=Dividend[7:0], DivZero=1 and Done=1 are registered at E0. Latency is 0 cycles after acceptance.
  - IDLE returns at E1, and the next Load can be accepted at E2.
- Not defined:
  - DivZero is tied to 0.
  - Divisor=0 runs the normal 16-step path and produces the same Quotient/Remainder values at E16.

## Test plan
- Rst high for 2 cycles, then released -> all outputs 0 and Busy=0. Load=0 -> block stays idle.
- Dividend=16'd1000, Divisor=8'd7, Load pulse -> Done at E16 with Quotient=16'd142 (0x008E), Remainder=8'd6; Busy low after E17.
- Back-to-back operations:
  - 65535/255 -> Quotient=16'd257, Remainder=0.
  - 5/9 -> Quotient=0, Remainder=5.
  - Load held high throughout -> Done pulses 18 cycles apart.
- Dividend=16'h1234, Divisor=0:
  - Trap defined -> Done at E0 with DivZero=1, Quotient=16'hFFFF, Remainder=8'h34.
  - Trap undefined -> Done at E16 with DivZero=0 and the same values.
- Load re-pulsed with different operands during CALC -> ignored; the result matches the first operands.
- Rst asserted at E8 of a divide -> no Done pulse, outputs 0 and state IDLE at that edge. A fresh 200/10 then returns Quotient=20, Remainder=0.
